// File: rtl/deserializer_if.sv
// deserializer_if: valid/ready stream bus for the deserializer.
// Signals: in_valid/in_ready/serial_in (serial side), out_valid/out_ready/data_out
// (frame side); in_sof/sof_err exist only when DESERIALIZER_SOF_EN is defined.
// Modports: master drives the serial input and consumes frames; slave is the deserializer.
interface deserializer_if #(parameter int SIZE = 4, parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] serial_in;
  logic out_valid;
  logic out_ready;
  logic [SIZE-1:0][WIDTH-1:0] data_out;
`ifdef DESERIALIZER_SOF_EN
  logic in_sof;
  logic sof_err;
`endif
  modport master(
    output in_valid, serial_in, out_ready,
`ifdef DESERIALIZER_SOF_EN
    output in_sof, input sof_err,
`endif
    input in_ready, out_valid, data_out
  );
  modport slave(
    input in_valid, serial_in, out_ready,
`ifdef DESERIALIZER_SOF_EN
    input in_sof, output sof_err,
`endif
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/deserializer.sv
// deserializer: collects SIZE words of WIDTH bits into a packed frame, word 0 first.
// Ports: clk, rst (async active-high), clear (sync flush), s (deserializer_if.slave):
// serial beats in over in_valid/in_ready/serial_in, frames out over out_valid/out_ready/data_out.
// Optional DESERIALIZER_SOF_EN adds in_sof framing and the sof_err pulse.
module deserializer #(
  parameter int SIZE = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  input logic clear,
  deserializer_if.slave s
);
  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);
  localparam logic [IW-1:0] ONE = IW'(1);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [SIZE-2:0][WIDTH-1:0] frame_buf;
  logic [SIZE-1:0][WIDTH-1:0] data_q;
`ifdef DESERIALIZER_SOF_EN
  logic sof_err_q;
  assign s.sof_err = sof_err_q;
`endif
  assign s.out_valid = (state == HOLD);
  assign s.in_ready = (state == FILL) | s.out_ready;
  assign s.data_out = data_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      idx <= '0;
      frame_buf <= '0;
      data_q <= '0;
`ifdef DESERIALIZER_SOF_EN
      sof_err_q <= 1'b0;
`endif
    end else begin
`ifdef DESERIALIZER_SOF_EN
      sof_err_q <= 1'b0;
`endif
      if (clear) begin
        state <= FILL;
        idx <= '0;
      end else if (state == HOLD) begin
        // a beat taken while the frame drains is always word 0 of the next frame
        if (s.out_ready) begin
          state <= FILL;
          idx <= s.in_valid ? ONE : '0;
          if (s.in_valid) frame_buf[0] <= s.serial_in;
        end
      end else if (s.in_valid) begin
`ifdef DESERIALIZER_SOF_EN
        if (s.in_sof) begin
          frame_buf[0] <= s.serial_in;
          idx <= ONE;
          sof_err_q <= (idx != '0);
        end else
`endif
        if (idx == LAST) begin
          data_q <= {s.serial_in, frame_buf};
          idx <= '0;
          state <= HOLD;
        end else begin
          for (int i = 0; i < SIZE - 1; i++)
            if (idx == IW'(i)) frame_buf[i] <= s.serial_in;
          idx <= idx + ONE;
        end
      end
    end
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed scoreboard bench for deserializer (SIZE=4, WIDTH=8).
module tb_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  deserializer_if #(.SIZE(4), .WIDTH(8)) bus();
  deserializer #(.SIZE(4), .WIDTH(8)) dut(.clk(clk), .rst(rst), .clear(clear), .s(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // consumer side: every consumed frame is popped from the scoreboard and compared
  always @(negedge clk)
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_frame", {32'h0, bus.data_out}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("frame", {32'h0, bus.data_out}, {32'h0, exp_q.pop_front()});
    end
  task automatic send(input logic [7:0] d, input logic sof = 1'b0);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.serial_in = d;
`ifdef DESERIALIZER_SOF_EN
    bus.in_sof = sof;
`else
    if (sof) $display("sof ignored");
`endif
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = (bus.in_ready === 1'b1);
      if (!ok) @(posedge clk);
    end
    if (!ok) chk("beat_timeout", 64'h0, 64'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
`ifdef DESERIALIZER_SOF_EN
    bus.in_sof = 1'b0;
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0;
    bus.in_valid = 1'b0;
    bus.serial_in = '0;
    bus.out_ready = 1'b1;
`ifdef DESERIALIZER_SOF_EN
    bus.in_sof = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
    chk("rst_data_out", {32'h0, bus.data_out}, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h44332211);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t1_out_valid_up", {63'h0, bus.out_valid}, 64'h1);
    @(posedge clk);
    #1;
    chk("t1_out_valid_one_cycle", {63'h0, bus.out_valid}, 64'h0);
    bus.out_ready = 1'b0;
    exp_q.push_back(32'h44332211);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {63'h0, bus.out_valid}, 64'h1);
      chk("bp_in_ready", {63'h0, bus.in_ready}, 64'h0);
      chk("bp_data_out", {32'h0, bus.data_out}, 64'h44332211);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    exp_q.push_back(32'h88776655);
    send(8'h55);
    chk("bp_release_fill", {63'h0, bus.out_valid}, 64'h0);
    send(8'h66); send(8'h77); send(8'h88);
    @(posedge clk);
    #1;
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    c0 = cyc;
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("b2b_cycles", 64'(cyc - c0), 64'd8);
    chk("b2b_last_valid", {63'h0, bus.out_valid}, 64'h1);
    @(posedge clk);
    #1;
    send(8'hAA); send(8'hBB);
    clear = 1'b1;
    send(8'hCC);
    clear = 1'b0;
    chk("clear_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("clear_keeps_data", {32'h0, bus.data_out}, 64'h08070605);
    exp_q.push_back(32'h04030201);
    for (int i = 1; i <= 4; i++) send(8'(i));
    @(posedge clk);
    #1;
    send(8'h21); send(8'h32);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("async_rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
    chk("async_rst_data_out", {32'h0, bus.data_out}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(32'hD4C3B2A1);
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    @(posedge clk);
    #1;
`ifdef DESERIALIZER_SOF_EN
    send(8'h10); send(8'h20);
    chk("sof_err_idle", {63'h0, bus.sof_err}, 64'h0);
    send(8'h30, 1'b1);
    chk("sof_err_pulse", {63'h0, bus.sof_err}, 64'h1);
    exp_q.push_back(32'h60504030);
    send(8'h40);
    chk("sof_err_drop", {63'h0, bus.sof_err}, 64'h0);
    send(8'h50); send(8'h60);
    chk("sof_err_low_at_end", {63'h0, bus.sof_err}, 64'h0);
    @(posedge clk);
    #1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
